// File: rtl/muntjac_pkg.sv
// muntjac_pkg: trace record and RVFI-DII v1 execution packet types with packet builders.
package muntjac_pkg;
  localparam int RvfiPktBeats = 11;
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] pc_wd;
    logic [31:0] instr_word;
    logic [4:0]  gpr;
    logic [63:0] gpr_data;
    logic [63:0] mem_addr;
    logic [63:0] mem_write_data;
    logic        trap;
  } instr_trace_t;
  typedef struct packed {
    logic [63:0] order;
    logic [63:0] pc_rdata;
    logic [63:0] pc_wdata;
    logic [63:0] insn;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] rd_wdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_rmask;
    logic [7:0]  mem_wmask;
    logic [7:0]  rs1_addr;
    logic [7:0]  rs2_addr;
    logic [7:0]  rd_addr;
    logic [7:0]  trap;
    logic [7:0]  halt;
    logic [7:0]  intr;
  } rvfi_pkt_t;
  function automatic rvfi_pkt_t rvfi_pkt_from_trace(instr_trace_t t, logic [63:0] order);
    rvfi_pkt_t p;
    p = '0;
    p.order = order;
    p.pc_rdata = t.pc;
    p.pc_wdata = t.pc_wd;
    p.insn = {32'b0, t.instr_word};
    p.rd_wdata = t.gpr_data;
    p.mem_addr = t.mem_addr;
    p.mem_wdata = t.mem_write_data;
    p.rd_addr = {3'b0, t.gpr};
    p.trap = {7'b0, t.trap};
    return p;
  endfunction
  function automatic rvfi_pkt_t rvfi_halt_pkt(logic [63:0] order);
    rvfi_pkt_t p;
    p = '0;
    p.order = order;
    p.halt = 8'd1;
    return p;
  endfunction
  // Byte fields go out little-endian, so the final beat reverses their declaration order.
  function automatic logic [63:0] rvfi_pkt_beat(rvfi_pkt_t p, logic [3:0] beat);
    int hi;
    hi = $bits(rvfi_pkt_t) - 1 - 64 * int'(beat);
    return beat == 4'd10 ? {p.intr, p.halt, p.trap, p.rd_addr, p.rs2_addr, p.rs1_addr, p.mem_wmask, p.mem_rmask}
                         : p[hi -: 64];
  endfunction
endpackage

// File: rtl/muntjac_rvfi_trace_fifo.sv
// muntjac_rvfi_trace_fifo: synchronous FIFO of trace records with full/empty flags.
module muntjac_rvfi_trace_fifo import muntjac_pkg::*; #(
  parameter int Depth = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr,
  input  instr_trace_t wdata,
  input  logic         rd,
  output instr_trace_t rdata,
  output logic         full,
  output logic         empty
);
  localparam int Aw = $clog2(Depth);
  instr_trace_t mem [Depth];
  logic [Aw:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[Aw] != rp[Aw]) && (wp[Aw-1:0] == rp[Aw-1:0]);
  assign rdata = mem[rp[Aw-1:0]];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk_i)
    if (wr) mem[wp[Aw-1:0]] <= wdata;
endmodule

// File: rtl/muntjac_rvfi_pkt_tx.sv
// muntjac_rvfi_pkt_tx: serialises buffered trace records and halt requests into RVFI-DII packets.
module muntjac_rvfi_pkt_tx import muntjac_pkg::*; #(
  parameter int FifoDepth = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  instr_trace_t trace_i,
  input  logic         halt_req_i,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output logic [63:0]  tx_data_o,
  output logic         tx_last_o,
  output logic         overflow_o,
  output logic         halt_done_o,
  output logic         busy_o
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  instr_trace_t head;
  rvfi_pkt_t pkt;
  logic [63:0] order;
  logic [3:0] beat;
  logic is_halt, halt_pending, full, empty, pop;
  assign pop = state == IDLE && !empty;
  muntjac_rvfi_trace_fifo #(.Depth(FifoDepth)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .wr(trace_i.valid && !full),
    .wdata(trace_i),
    .rd(pop),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  assign tx_valid_o = state == SEND;
  assign tx_last_o = tx_valid_o && beat == 4'(RvfiPktBeats - 1);
  assign tx_data_o = tx_valid_o ? rvfi_pkt_beat(pkt, beat) : '0;
  assign busy_o = !empty || tx_valid_o || halt_pending;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      pkt <= '0;
      order <= '0;
      beat <= '0;
      is_halt <= 1'b0;
      halt_pending <= 1'b0;
      overflow_o <= 1'b0;
      halt_done_o <= 1'b0;
    end else begin
      halt_done_o <= 1'b0;
      if (trace_i.valid && full) overflow_o <= 1'b1;
      if (state == IDLE) begin
        if (!empty || halt_pending) begin
          pkt <= !empty ? rvfi_pkt_from_trace(head, order) : rvfi_halt_pkt(order);
          is_halt <= empty;
          beat <= '0;
          state <= SEND;
        end
      end else if (tx_ready_i) begin
        beat <= beat + 1'b1;
        if (tx_last_o) begin
          state <= IDLE;
          if (is_halt) begin
            halt_pending <= 1'b0;
            halt_done_o <= 1'b1;
          end else order <= order + 1'b1;
        end
      end
      // A request landing on the completion cycle asks for a fresh halt packet.
      if (halt_req_i) halt_pending <= 1'b1;
    end
endmodule

// File: tb/tb_muntjac_rvfi_pkt_tx.sv
// tb_muntjac_rvfi_pkt_tx: scoreboard bench for the RVFI-DII packet transmitter.
module tb_muntjac_rvfi_pkt_tx;
  import muntjac_pkg::*;
  typedef struct {logic [63:0] d; logic l;} beat_t;
  logic clk = 0, rst = 1, halt_req = 0, tx_valid, tx_ready = 1, tx_last, overflow, halt_done, busy;
  logic [63:0] tx_data;
  instr_trace_t trace = '0;
  beat_t exp_q[$];
  int checks = 0, errors = 0, halt_cnt = 0, acc_cnt = 0, mode = 0;
  logic tgl = 0, prev_stall = 0, prev_last;
  logic [63:0] prev_data;

  muntjac_rvfi_pkt_tx #(.FifoDepth(4)) dut (
    .clk_i(clk), .rst_i(rst), .trace_i(trace), .halt_req_i(halt_req),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data), .tx_last_o(tx_last),
    .overflow_o(overflow), .halt_done_o(halt_done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic void push_beats(input logic [63:0] ord, pc, pcw, ins, rd, ma, mwd, b10);
    logic [63:0] v [11];
    v = '{ord, pc, pcw, ins, 64'd0, 64'd0, rd, ma, 64'd0, mwd, b10};
    for (int i = 0; i < 11; i++) exp_q.push_back('{d: v[i], l: i == 10});
  endfunction

  task automatic send_trace(input logic [63:0] ord, pc, pcw, input logic [31:0] ins, input logic [4:0] g,
                            input logic [63:0] gd, ma, mwd, input logic tr, input bit expect_pkt);
    trace.valid = 1;
    trace.pc = pc;
    trace.pc_wd = pcw;
    trace.instr_word = ins;
    trace.gpr = g;
    trace.gpr_data = gd;
    trace.mem_addr = ma;
    trace.mem_write_data = mwd;
    trace.trap = tr;
    if (expect_pkt)
      push_beats(ord, pc, pcw, {32'b0, ins}, gd, ma, mwd, {16'b0, 7'b0, tr, 3'b0, g, 32'b0});
    step();
    trace.valid = 0;
  endtask

  task automatic wait_drain(input string n);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || busy); i++) step();
    chk(n, {63'b0, exp_q.size() == 0 && !busy}, 64'd1);
  endtask

  always @(posedge clk) begin
    #1;
    tgl = ~tgl;
    tx_ready = mode == 0 ? 1'b1 : mode == 2 ? 1'b0 : (tgl && $urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", {63'b0, tx_valid}, 64'd1);
        chk("stall_data", tx_data, prev_data);
        chk("stall_last", {63'b0, tx_last}, {63'b0, prev_last});
      end
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("unexpected_beat", tx_data, 64'hx);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_data", tx_data, b.d);
          chk("beat_last", {63'b0, tx_last}, {63'b0, b.l});
        end
      end
      if (halt_done) halt_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      prev_last = tx_last;
    end
  end

  initial begin
    int a0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_valid", {63'b0, tx_valid}, 64'd0);
    chk("rst_data", tx_data, 64'd0);
    chk("rst_last", {63'b0, tx_last}, 64'd0);
    chk("rst_overflow", {63'b0, overflow}, 64'd0);
    chk("rst_halt_done", {63'b0, halt_done}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    step();
    rst = 0;
    step();
    // single record with latency checks
    send_trace(0, 64'h8000_0000, 64'h8000_0004, 32'h0050_0093, 5'd1, 64'd5, 64'd0, 64'd0, 1'b0, 1);
    chk("lat_n1_valid", {63'b0, tx_valid}, 64'd0);
    chk("lat_n1_busy", {63'b0, busy}, 64'd1);
    step();
    chk("lat_n2_valid", {63'b0, tx_valid}, 64'd1);
    chk("lat_n2_beat0", tx_data, 64'd0);
    wait_drain("drain_single");
    // back-to-back records
    send_trace(1, 64'h8000_0004, 64'h8000_0008, 32'h0010_8113, 5'd2, 64'd6, 64'd0, 64'd0, 1'b0, 1);
    send_trace(2, 64'h8000_0008, 64'h8000_000c, 32'h0020_b023, 5'd0, 64'd0, 64'h1000, 64'h6, 1'b0, 1);
    send_trace(3, 64'h8000_000c, 64'h8000_0100, 32'h0000_0073, 5'd31, 64'hdead_beef, 64'd0, 64'd0, 1'b1, 1);
    wait_drain("drain_b2b");
    chk("b2b_busy_low", {63'b0, busy}, 64'd0);
    // backpressure
    mode = 1;
    send_trace(4, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 32'hffff_ffff, 5'd17, 64'h0123_4567_89ab_cdef, 64'h2000, 64'h99, 1'b1, 1);
    send_trace(5, 64'h10, 64'h14, 32'h0000_0013, 5'd3, 64'd7, 64'd0, 64'd0, 1'b0, 1);
    send_trace(6, 64'h8000_0000, 64'h8000_0004, 32'h0050_0093, 5'd1, 64'd5, 64'd0, 64'd0, 1'b0, 1);
    wait_drain("drain_bp");
    // overflow
    mode = 2;
    step();
    for (int i = 0; i < 5; i++)
      send_trace(64'(7 + i), 64'(32'h100 + 4 * i), 64'(32'h104 + 4 * i), 32'h13, 5'(i), 64'(i), 64'd0, 64'd0, 1'b0, 1);
    chk("ovf_before", {63'b0, overflow}, 64'd0);
    send_trace(0, 64'h999, 64'h99d, 32'h13, 5'd9, 64'd9, 64'd0, 64'd0, 1'b0, 0);
    chk("ovf_after", {63'b0, overflow}, 64'd1);
    mode = 0;
    wait_drain("drain_ovf");
    chk("ovf_sticky", {63'b0, overflow}, 64'd1);
    // halt ordering
    halt_cnt = 0;
    halt_req = 1;
    send_trace(12, 64'h200, 64'h204, 32'h0050_0093, 5'd4, 64'd8, 64'd0, 64'd0, 1'b0, 1);
    halt_req = 0;
    push_beats(13, 0, 0, 0, 0, 0, 0, 64'h0001_0000_0000_0000);
    step();
    step();
    halt_req = 1;
    step();
    halt_req = 0;
    wait_drain("drain_halt");
    step();
    chk("halt_done_count", 64'(halt_cnt), 64'd1);
    // reset mid-packet
    a0 = acc_cnt;
    send_trace(13, 64'h300, 64'h304, 32'h13, 5'd5, 64'd1, 64'd0, 64'd0, 1'b0, 1);
    for (int i = 0; i < 100 && acc_cnt != a0 + 5; i++) step();
    chk("mid_pkt_reached", 64'(acc_cnt - a0), 64'd5);
    rst = 1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_valid", {63'b0, tx_valid}, 64'd0);
    chk("mid_rst_overflow", {63'b0, overflow}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    step();
    rst = 0;
    step();
    send_trace(0, 64'h400, 64'h404, 32'h0050_0093, 5'd6, 64'd2, 64'd0, 64'd0, 1'b0, 1);
    wait_drain("drain_post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
